// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode fields, write-back data-select codes and register indices shared by the pipeline.
package cpu_pkg;
  localparam logic [3:0] OP_STACK = 4'h7;
  localparam logic [1:0] STK_PUSH = 2'b00;
  localparam logic [1:0] STK_POP = 2'b01;
  localparam logic [2:0] WBSEL_ALU = 3'd0;
  localparam logic [2:0] WBSEL_MEM = 3'd1;
  localparam logic [2:0] WBSEL_IMM = 3'd2;
  localparam logic [2:0] WBSEL_IN = 3'd3;
  localparam logic [2:0] WBSEL_MOV = 3'd4;
  localparam logic [2:0] WBSEL_SP = 3'd5;
  localparam logic [1:0] SP_IDX = 2'd3;
endpackage

// File: rtl/regfile_4x8.sv
// regfile_4x8: four-entry register file with a data write port, a stack-pointer write port
// and two write-first read ports; a data write to R3 overrides a same-cycle stack update.
module regfile_4x8
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_sp_we,
  input  logic [DATA_W-1:0] i_sp_wdata,
  input  logic [1:0]        i_rd_addr_a,
  input  logic [1:0]        i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_a,
  output logic [DATA_W-1:0] o_rd_data_b,
  output logic [DATA_W-1:0] o_sp_out
);
  logic [DATA_W-1:0] r_regs [4];
  logic w_sp_hit;
  assign w_sp_hit = i_sp_we && !(i_we && i_waddr == SP_IDX);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs[0] <= '0;
      r_regs[1] <= '0;
      r_regs[2] <= '0;
      r_regs[3] <= SP_RESET;
    end else begin
      if (w_sp_hit) r_regs[SP_IDX] <= i_sp_wdata;
      if (i_we) r_regs[i_waddr] <= i_wdata;
    end
  end
  function automatic logic [DATA_W-1:0] rd(input logic [1:0] a);
    return (i_we && a == i_waddr) ? i_wdata :
           (w_sp_hit && a == SP_IDX) ? i_sp_wdata : r_regs[a];
  endfunction
  assign o_rd_data_a = rd(i_rd_addr_a);
  assign o_rd_data_b = rd(i_rd_addr_b);
  assign o_sp_out = rd(SP_IDX);
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage; selects the result word, decodes stack updates, commits to the
// register file and drives the registered output port.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        opcode_wb,
  input  logic [DATA_W-1:0] alu_out_WB,
  input  logic [DATA_W-1:0] mem_data_WB,
  input  logic [DATA_W-1:0] Sp_WB,
  input  logic [DATA_W-1:0] imm_WB,
  input  logic [DATA_W-1:0] input_port_WB,
  input  logic [DATA_W-1:0] R_ra_WB,
  input  logic [DATA_W-1:0] R_rb_WB,
  input  logic              w_E_R_WB,
  input  logic              w_Add_S_R_WB,
  input  logic [2:0]        w_Data_S_R_WB,
  input  logic              Out_E_WB,
  input  logic [1:0]        ra_WB,
  input  logic [1:0]        rb_WB,
  input  logic [1:0]        rd_addr_a,
  input  logic [1:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] sp_out,
  output logic              fwd_we,
  output logic [1:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid
);
  logic w_stack;
  logic w_unused;
  logic [DATA_W-1:0] r_out_port;
  logic r_out_valid;
  assign w_unused = &{1'b0, opcode_wb[1:0], R_ra_WB};
  always_comb begin
    fwd_data = (w_Data_S_R_WB == WBSEL_ALU) ? alu_out_WB :
               (w_Data_S_R_WB == WBSEL_MEM) ? mem_data_WB :
               (w_Data_S_R_WB == WBSEL_IMM) ? imm_WB :
               (w_Data_S_R_WB == WBSEL_IN)  ? input_port_WB :
               (w_Data_S_R_WB == WBSEL_MOV) ? R_rb_WB :
               (w_Data_S_R_WB == WBSEL_SP)  ? Sp_WB : '0;
    fwd_we = w_E_R_WB && w_Data_S_R_WB <= WBSEL_SP;
    fwd_addr = w_Add_S_R_WB ? rb_WB : ra_WB;
    w_stack = opcode_wb[7:4] == OP_STACK &&
              (opcode_wb[3:2] == STK_PUSH || opcode_wb[3:2] == STK_POP);
  end
  regfile_4x8 #(.DATA_W(DATA_W), .SP_RESET(SP_RESET)) u_rf (
    .clk(clk), .rst(rst),
    .i_we(fwd_we), .i_waddr(fwd_addr), .i_wdata(fwd_data),
    .i_sp_we(w_stack), .i_sp_wdata(Sp_WB),
    .i_rd_addr_a(rd_addr_a), .i_rd_addr_b(rd_addr_b),
    .o_rd_data_a(rd_data_a), .o_rd_data_b(rd_data_b), .o_sp_out(sp_out)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_port <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= Out_E_WB;
      if (Out_E_WB) r_out_port <= R_rb_WB;
    end
  end
  assign out_port = r_out_port;
  assign out_valid = r_out_valid;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed write-back vectors with hand-computed expectations.
module tb_wb_regfile;
  logic clk = 0, rst = 1;
  logic [7:0] opcode_wb = 0, alu_out_WB = 0, mem_data_WB = 0, Sp_WB = 0, imm_WB = 0;
  logic [7:0] input_port_WB = 0, R_ra_WB = 0, R_rb_WB = 0;
  logic w_E_R_WB = 0, w_Add_S_R_WB = 0, Out_E_WB = 0;
  logic [2:0] w_Data_S_R_WB = 0;
  logic [1:0] ra_WB = 0, rb_WB = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [7:0] rd_data_a, rd_data_b, sp_out, fwd_data, out_port;
  logic fwd_we, out_valid;
  logic [1:0] fwd_addr;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  wb_regfile dut (
    .clk(clk), .rst(rst), .opcode_wb(opcode_wb), .alu_out_WB(alu_out_WB),
    .mem_data_WB(mem_data_WB), .Sp_WB(Sp_WB), .imm_WB(imm_WB), .input_port_WB(input_port_WB),
    .R_ra_WB(R_ra_WB), .R_rb_WB(R_rb_WB), .w_E_R_WB(w_E_R_WB), .w_Add_S_R_WB(w_Add_S_R_WB),
    .w_Data_S_R_WB(w_Data_S_R_WB), .Out_E_WB(Out_E_WB), .ra_WB(ra_WB), .rb_WB(rb_WB),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .sp_out(sp_out), .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_port(out_port), .out_valid(out_valid)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
  endtask
  initial begin
    tick();
    rst = 0;
    rd(0, 1); chk("rst_r0", rd_data_a, 8'h00); chk("rst_r1", rd_data_b, 8'h00);
    rd(2, 3); chk("rst_r2", rd_data_a, 8'h00); chk("rst_r3", rd_data_b, 8'hFF);
    chk("rst_sp", sp_out, 8'hFF); chk("rst_out", out_port, 8'h00); chk("rst_ov", {7'b0, out_valid}, 8'h00);
    // ALU write to R2 with same-cycle decode read
    w_E_R_WB = 1; w_Data_S_R_WB = 0; ra_WB = 2; alu_out_WB = 8'h3C; rd(2, 0);
    chk("alu_byp", rd_data_a, 8'h3C); chk("alu_fwe", {7'b0, fwd_we}, 8'h01);
    chk("alu_fad", {6'b0, fwd_addr}, 8'h02); chk("alu_fdat", fwd_data, 8'h3C);
    tick(); w_E_R_WB = 0; #1;
    chk("alu_stored", rd_data_a, 8'h3C);
    // POP colliding with a data write to R3: data wins
    opcode_wb = 8'h74; w_E_R_WB = 1; w_Data_S_R_WB = 1; ra_WB = 3; mem_data_WB = 8'hA5; Sp_WB = 8'h10;
    rd(3, 2);
    chk("col_byp", rd_data_a, 8'hA5); chk("col_sp", sp_out, 8'hA5);
    tick(); opcode_wb = 0; w_E_R_WB = 0; #1;
    chk("col_r3", rd_data_a, 8'hA5); chk("col_r2", rd_data_b, 8'h3C);
    // non-colliding POP: R1 gets data, R3 gets Sp
    opcode_wb = 8'h74; w_E_R_WB = 1; ra_WB = 1; rd(3, 1);
    chk("pop_sp_byp", rd_data_a, 8'h10); chk("pop_r1_byp", rd_data_b, 8'hA5);
    tick(); opcode_wb = 0; w_E_R_WB = 0; #1;
    chk("pop_r3", rd_data_a, 8'h10); chk("pop_r1", rd_data_b, 8'hA5); chk("pop_spo", sp_out, 8'h10);
    // PUSH without a data write; MOV into rb-selected R0 same cycle
    opcode_wb = 8'h70; Sp_WB = 8'h0F; w_E_R_WB = 1; w_Add_S_R_WB = 1; rb_WB = 0; ra_WB = 3;
    w_Data_S_R_WB = 4; R_rb_WB = 8'h99; rd(0, 3);
    chk("mov_fad", {6'b0, fwd_addr}, 8'h00); chk("mov_byp", rd_data_a, 8'h99); chk("push_byp", sp_out, 8'h0F);
    tick(); opcode_wb = 0; w_E_R_WB = 0; w_Add_S_R_WB = 0; #1;
    chk("mov_r0", rd_data_a, 8'h99); chk("push_r3", rd_data_b, 8'h0F);
    // non-stack opcode leaves R3 alone; imm and SP selects
    opcode_wb = 8'h7C; Sp_WB = 8'h44; w_E_R_WB = 1; ra_WB = 1; w_Data_S_R_WB = 2; imm_WB = 8'h5A; rd(1, 3);
    chk("imm_byp", rd_data_a, 8'h5A); chk("nostk_r3", rd_data_b, 8'h0F);
    tick(); w_Data_S_R_WB = 5; ra_WB = 2; opcode_wb = 0; rd(2, 3);
    chk("spsel_byp", rd_data_a, 8'h44);
    tick(); w_E_R_WB = 0; #1;
    chk("spsel_r2", rd_data_a, 8'h44); chk("nostk_r3b", rd_data_b, 8'h0F);
    // reserved select suppresses the write
    w_E_R_WB = 1; w_Data_S_R_WB = 6; ra_WB = 2; alu_out_WB = 8'hEE; rd(2, 1);
    chk("rsv_fwe", {7'b0, fwd_we}, 8'h00); chk("rsv_byp", rd_data_a, 8'h44);
    w_Data_S_R_WB = 7; #1; chk("rsv7_fwe", {7'b0, fwd_we}, 8'h00);
    tick(); w_E_R_WB = 0; #1;
    chk("rsv_r2", rd_data_a, 8'h44); chk("rsv_r1", rd_data_b, 8'h5A);
    // output port: single, then back-to-back
    Out_E_WB = 1; R_rb_WB = 8'h7E; #1;
    chk("out_pre", out_port, 8'h00);
    tick(); Out_E_WB = 0; #1;
    chk("out_port", out_port, 8'h7E); chk("out_v1", {7'b0, out_valid}, 8'h01);
    tick();
    chk("out_hold", out_port, 8'h7E); chk("out_v0", {7'b0, out_valid}, 8'h00);
    Out_E_WB = 1; R_rb_WB = 8'h11; tick(); R_rb_WB = 8'h22;
    chk("b2b_p1", out_port, 8'h11); chk("b2b_v1", {7'b0, out_valid}, 8'h01);
    tick(); Out_E_WB = 0;
    chk("b2b_p2", out_port, 8'h22); chk("b2b_v2", {7'b0, out_valid}, 8'h01);
    // reset coincident with a write: reset wins
    rst = 1; w_E_R_WB = 1; w_Data_S_R_WB = 0; ra_WB = 0; alu_out_WB = 8'h55; rd(0, 3);
    chk("rstw_fdat", fwd_data, 8'h55);
    tick(); rst = 0; w_E_R_WB = 0; #1;
    chk("rstw_r0", rd_data_a, 8'h00); chk("rstw_r3", rd_data_b, 8'hFF);
    chk("rstw_out", out_port, 8'h00); chk("rstw_ov", {7'b0, out_valid}, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

- Write-back end of the MEM/WB interface.
- Consumes the WB-stage outputs of the MEM/WB pipeline register and commits results into the 4×8 general register file (R3 doubles as stack pointer).
- Drives the registered output port.
- Serves decode with two combinational read ports that bypass the in-flight write-back value.

## Interface
- `DATA_W`, 8, datapath width
- `SP_RESET`, 8'hFF, reset value of R3 (stack pointer)
- `clk` in 1: system clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `opcode_wb` in 8: instruction opcode in WB
- `alu_out_WB`, `mem_data_WB`, `Sp_WB`, `imm_WB`, `input_port_WB` in 8 each: candidate write data
- `R_ra_WB`, `R_rb_WB` in 8 each: operand values carried down the pipe
- `w_E_R_WB` in 1: register write enable
- `w_Add_S_R_WB` in 1: destination select, 0 = `ra_WB`, 1 = `rb_WB`
- `w_Data_S_R_WB` in 3: write data select
- `Out_E_WB` in 1: output port write enable
- `ra_WB`, `rb_WB` in 2 each: register indices
- `rd_addr_a`, `rd_addr_b` in 2 each: decode read addresses
- `rd_data_a`, `rd_data_b` out 8 each: decode read data, bypassed
- `sp_out` out 8: current R3, to MEM stage
- `fwd_we`, `fwd_addr` (2), `fwd_data` (8) out: this cycle's commit, for the forwarding unit
- `out_port` out 8: registered output port
- `out_valid` out 1: one-cycle strobe when `out_port` updates

## Operation
- Data select, `w_Data_S_R_WB`:
  - 0 = `alu_out_WB`
  - 1 = `mem_data_WB`
  - 2 = `imm_WB`
  - 3 = `input_port_WB`
  - 4 = `R_rb_WB` (MOV)
  - 5 = `Sp_WB`
  - 6, 7 = reserved: write suppressed, `fwd_we`=0
- `fwd_we` = `w_E_R_WB` and select ≤5.
- `fwd_addr` = `w_Add_S_R_WB` ? `rb_WB` : `ra_WB`.
- `fwd_data` = the selected word.
- Stack update:
  - Condition: `opcode_wb[7:4]` == `OP_STACK` (4'h7) and `opcode_wb[3:2]` ∈ {`STK_PUSH` 2'b00, `STK_POP` 2'b01}.
  - Effect: R3 ← `Sp_WB`, independent of `fwd_we`.
- Collision rule: stack update and data write both targeting R3 in the same cycle → the data write wins, `Sp_WB` is discarded.
- Output port: `Out_E_WB`=1 → `out_port` ← `R_rb_WB` and `out_valid`=1 for exactly the following cycle. Otherwise `out_valid`=0 and `out_port` holds.
- Read ports are write-first: if `fwd_we` and `rd_addr_x`==`fwd_addr`, `rd_data_x`=`fwd_data`.
- Pending stack update with `rd_addr_x`==3 and no data write to R3 → `rd_data_x`=`Sp_WB`.
- Otherwise `rd_data_x` = stored register.
- `sp_out` follows the same bypass rule for address 3.
- All arithmetic is done upstream; this block only selects and stores, with no width change.

## Timing
- Reset (synchronous, `rst`=1 at the edge):
  - R0–R2 = 0, R3 = `SP_RESET`
  - `out_port` = 0, `out_valid` = 0
- Combinational outputs during reset: `fwd_*` reflect inputs; reads return reset-state contents unless bypassed.
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- Commit latency: write visible combinationally on `rd_data`/`fwd_*` in the WB cycle, stored at the next rising edge. Zero bubbles for a dependent decode read.
- `out_port` and `out_valid` change one edge after `Out_E_WB` is sampled.
- Back-to-back OUTs: `out_valid` stays high, `out_port` updates every cycle.
- No stall or flush inputs. An upstream bubble must arrive with `w_E_R_WB`=0, `Out_E_WB`=0 and a non-stack opcode.

## Structure
- Shared package `cpu_pkg`:
  - `OP_STACK`, `STK_PUSH`, `STK_POP`
  - WB data-select constants `WBSEL_ALU`..`WBSEL_SP`
  - `SP_IDX` = 2'd3
- Natural sub-module `regfile_4x8`: storage, a write port plus SP write port with the priority rule, two read ports with bypass.
- Top level holds: data-select mux, stack decode, output port register.

## Test plan
- Reset: assert `rst` one cycle → all reads give 0 except addr 3 = 8'hFF; `out_port`=0, `out_valid`=0.
- ALU write plus same-cycle read: `w_E_R`=1, sel=0, `ra_WB`=2, `alu_out`=8'h3C, `rd_addr_a`=2 → `rd_data_a`=8'h3C that cycle and after the edge.
- POP collision: opcode 8'h74, `ra_WB`=3, sel=1, `mem_data`=8'hA5, `Sp_WB`=8'h10 → R3 = 8'hA5.
- Non-colliding POP: same as above with `ra_WB`=1 → R1 = 8'hA5, R3 = 8'h10.
- Reserved select: sel=6, `w_E_R`=1 → `fwd_we`=0 and no register changes.
- OUT then reset mid-run: `Out_E`=1, `R_rb_WB`=8'h7E → next cycle `out_port`=8'h7E, `out_valid`=1 for one cycle. Then `rst` coincident with a write of 8'h55 to R0 → R0=0 and `out_port`=0.
